serial_frame_tx: RTL and testbench

Serial frame transmitter: accepts a parallel word over a valid/ready handshake and drives it out one bit at a time on a single registered line. Frame format is start bit, data LSB first, optional parity bit, stop bit. It is the transmitting end for the registered single-bit capture stage that samples the serial line on the far side. It sits between a parallel data source and the serial pin.

---
 rtl/serial_frame_pkg.sv | 17 +
 rtl/serial_baud_tick.sv | 31 +++
 rtl/serial_frame_tx.sv | 127 ++++++++++++
 tb/tb_serial_frame_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and line constants for the serial frame transmitter.
// Even parity is compiled in when SERIAL_FRAME_TX_PARITY_EN is defined.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_baud_tick.sv
// Baud counter: runs 0..BAUD_DIV-1 while enabled and flags the terminal cycle.
// Holding clear keeps it at 0 so the first bit of a frame gets a full period.
module serial_baud_tick #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  // Wrapping on tick keeps the counter inside 0..BAUD_DIV-1, including BAUD_DIV=1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) cnt_d = '0;
    else               cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W bits LSB first, optional even parity
// (SERIAL_FRAME_TX_PARITY_EN), stop bit. tx is registered from the next state.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic              tx_q,    tx_d;
  logic              done_q,  done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par_q,   par_d;
`endif
  logic              tick;

  serial_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    tx_d    = LINE_IDLE;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = START;
          shift_d = data;
          idx_d   = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_BIT) begin
            idx_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the same edge.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      STOP:    tx_d = STOP_BIT;
      default: tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
      done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: instance 0 at BAUD_DIV=4, instance 1 at BAUD_DIV=1.
// A negedge monitor captures each frame on tx and compares it to a bit-list model.
module tb_serial_frame_tx;

  localparam int DW = 8;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB     = DW + 2 + PB;
  localparam int MAXLEN = NB * 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    vld = 2'b00;
  logic [1:0]    rdy, txl, bsy, dn;
  logic [DW-1:0] dat [2];

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(DW), .BAUD_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .data(dat[0]), .valid(vld[0]),
    .ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .done(dn[0])
  );

  serial_frame_tx #(.DATA_W(DW), .BAUD_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .data(dat[1]), .valid(vld[1]),
    .ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .done(dn[1])
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
  endtask

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  function automatic int baud(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic void pushq(input int k, input logic [DW-1:0] w);
    if (k == 0) q0.push_back(w);
    else        q1.push_back(w);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [DW-1:0] popq(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Frame as a list of bit positions: start, data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int p);
    if (p == 0) return 1'b0;
    if (p <= DW) return w[p-1];
    if (PB == 1 && p == DW + 1) return ^w;
    return 1'b1;
  endfunction

  bit   col  [2] = '{0, 0};
  bit   pend [2] = '{0, 0};
  bit   bad  [2] = '{0, 0};
  int   n    [2] = '{0, 0};
  int   gap  [2] = '{-1, -1};
  int   lend [2] = '{0, 0};
  int   dcnt [2] = '{0, 0};
  int   dexp [2] = '{0, 0};
  int   cyc = 0;
  logic smp [2][0:MAXLEN-1];

  always @(negedge clk) begin : monitor
    logic [63:0]   act, ev;
    logic [DW-1:0] w;
    int            bd;
    for (int k = 0; k < 2; k++) begin
      bd = baud(k);
      if (!reset) begin
        if (col[k]) begin
          if (qsize(k) > 0) w = popq(k);
          col[k] = 1'b0;
        end
        pend[k] = 1'b0;
      end else begin
        if (pend[k]) begin
          pend[k] = 1'b0;
          chk(dn[k] && rdy[k], $sformatf("end of frame done/ready dut%0d", k), {dn[k], rdy[k]}, 2'b11);
        end
        if (!col[k]) begin
          if (txl[k] == 1'b0) begin
            col[k]    = 1'b1;
            bad[k]    = !bsy[k];
            smp[k][0] = txl[k];
            n[k]      = 1;
            gap[k]    = cyc - lend[k] - 1;
          end
        end else begin
          smp[k][n[k]] = txl[k];
          if (!bsy[k] || dn[k]) bad[k] = 1'b1;
          n[k]++;
          if (n[k] == NB * bd) begin
            col[k]  = 1'b0;
            pend[k] = 1'b1;
            lend[k] = cyc;
            if (qsize(k) == 0) begin
              chk(1'b0, $sformatf("unexpected frame dut%0d", k), 64'd1, 64'd0);
            end else begin
              w   = popq(k);
              act = '0;
              ev  = '0;
              for (int i = 0; i < NB * bd; i++) begin
                act[i] = smp[k][i];
                ev[i]  = exp_bit(w, i / bd);
              end
              chk(act == ev && !bad[k], $sformatf("frame dut%0d word %02h busy_ok=%0d", k, w, !bad[k]), act, ev);
            end
          end
        end
      end
      if (dn[k]) dcnt[k]++;
    end
    cyc++;
  end

  task automatic send(input int k, input logic [DW-1:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy[k] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[k]) begin
      chk(1'b0, $sformatf("ready timeout dut%0d", k), 64'd0, 64'd1);
      return;
    end
    vld[k] = 1'b1;
    dat[k] = w;
    pushq(k, w);
    dexp[k]++;
    @(negedge clk);
    vld[k] = 1'b0;
    dat[k] = DW'($urandom);
    chk(txl[k] == 1'b0 && rdy[k] == 1'b0, $sformatf("start latency dut%0d", k), {txl[k], rdy[k]}, 2'b00);
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((qsize(k) != 0 || col[k] || pend[k] || !rdy[k]) && t < 3000);
    if (t >= 3000) chk(1'b0, $sformatf("idle timeout dut%0d", k), 64'd0, 64'd1);
  endtask

  initial begin
    int t;
    dat[0] = '0;
    dat[1] = '0;
    #7;
    for (int k = 0; k < 2; k++)
      chk(txl[k] && rdy[k] && !bsy[k] && !dn[k], $sformatf("in reset dut%0d", k),
          {txl[k], rdy[k], bsy[k], dn[k]}, 4'b1100);
    #15 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk(txl[k] && rdy[k] && !bsy[k] && !dn[k], $sformatf("after reset dut%0d", k),
          {txl[k], rdy[k], bsy[k], dn[k]}, 4'b1100);

    send(0, 8'hA5);
    wait_idle(0);
    send(0, 8'h01);
    wait_idle(0);

    // valid held high across two frames, data changed while the first is in flight
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'h3C;
    pushq(0, 8'h3C);
    dexp[0]++;
    @(negedge clk);
    dat[0] = 8'hC3;
    pushq(0, 8'hC3);
    dexp[0]++;
    t = 0;
    while (!rdy[0] && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (5) @(negedge clk);
    dat[0] = 8'h5A;
    wait_idle(0);
    chk(gap[0] == 1, "back-to-back idle gap", 64'(gap[0]), 64'd1);

    // reset during data bit 3
    send(0, 8'h96);
    repeat (17) @(negedge clk);
    #2 reset = 1'b0;
    dexp[0]--;
    #1;
    chk(txl[0] && rdy[0] && !bsy[0] && !dn[0], "async reset mid-frame",
        {txl[0], rdy[0], bsy[0], dn[0]}, 4'b1100);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    send(0, 8'h6B);
    wait_idle(0);

    // random words with valid pulses while busy, which must be ignored
    repeat (12) begin
      send(0, DW'($urandom));
      repeat (3) @(negedge clk);
      vld[0] = 1'b1;
      dat[0] = DW'($urandom);
      repeat (2) @(negedge clk);
      vld[0] = 1'b0;
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end
    wait_idle(0);

    send(1, 8'hFF);
    wait_idle(1);
    repeat (6) begin
      send(1, DW'($urandom));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle(1);

    for (int k = 0; k < 2; k++) begin
      chk(dcnt[k] == dexp[k], $sformatf("done pulse count dut%0d", k), 64'(dcnt[k]), 64'(dexp[k]));
      chk(qsize(k) == 0, $sformatf("scoreboard drained dut%0d", k), 64'(qsize(k)), 64'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
